// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the two requesters and the register file port.
// master: requesters + register file side; slave: the arbiter.
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int NREG   = 8
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              rf_write;
  logic [ADDR_W-1:0] rf_inaddress;
  logic [DATA_W-1:0] rf_in;
  logic [NREG-1:0]   pending;
  logic              last_grant;

  modport master (
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    input  rf_write, rf_inaddress, rf_in,
    input  pending, last_grant
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    output rf_write, rf_inaddress, rf_in,
    output pending, last_grant
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between
// ALU (req0) and load (req1) writeback; ports: CLK, RESET, hold, bus.
module regfile_write_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int NREG   = 8
) (
  input  logic CLK,
  input  logic RESET,
  input  logic hold,
  regfile_write_arbiter_if.slave bus
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [NREG-1:0]   pend_q;
  logic              lg_q;

  logic              gnt0;
  logic              gnt1;
  logic              xfer;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] data_sel;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!RESET && !hold) begin
      gnt0 = bus.req0_valid
           && (!bus.req1_valid || lg_q);
      gnt1 = bus.req1_valid
           && (!bus.req0_valid || !lg_q);
    end
  end

  assign xfer     = gnt0 | gnt1;
  assign addr_sel = gnt1 ? bus.req1_addr : bus.req0_addr;
  assign data_sel = gnt1 ? bus.req1_data : bus.req0_data;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      pend_q <= '0;
      lg_q   <= 1'b1;
    end else if (xfer) begin
      state  <= WRITE;
      addr_q <= addr_sel;
      data_q <= data_sel;
      pend_q <= NREG'(1) << addr_sel;
      lg_q   <= gnt1;
    end else begin
      state  <= IDLE;
      pend_q <= '0;
    end
  end

  assign bus.req0_ready   = gnt0;
  assign bus.req1_ready   = gnt1;
  assign bus.rf_write     = (state == WRITE);
  assign bus.rf_inaddress = addr_q;
  assign bus.rf_in        = data_q;
  assign bus.pending      = pend_q;
  assign bus.last_grant   = lg_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed vector bench for regfile_write_arbiter with a small
// register file model fed from the rf_* outputs.
module tb_regfile_write_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic hold;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter dut (
    .CLK   (clk),
    .RESET (rst),
    .hold  (hold),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] rf_mem [8];

  // Register file: write qualified by reset on the same edge.
  always @(posedge clk)
    if (!rst && bus.rf_write)
      rf_mem[bus.rf_inaddress] <= bus.rf_in;

  typedef struct {
    logic       rst;
    logic       hold;
    logic       v0;
    logic [2:0] a0;
    logic [7:0] d0;
    logic       v1;
    logic [2:0] a1;
    logic [7:0] d1;
    logic       r0;
    logic       r1;
    logic       wr;
    logic [2:0] addr;
    logic [7:0] data;
    logic [7:0] pend;
    logic       lg;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst            = v.rst;
    hold           = v.hold;
    bus.req0_valid = v.v0;
    bus.req0_addr  = v.a0;
    bus.req0_data  = v.d0;
    bus.req1_valid = v.v1;
    bus.req1_addr  = v.a1;
    bus.req1_data  = v.d1;
  endtask

  vec_t vt [18];

  initial begin
    for (int i = 0; i < 8; i++) rf_mem[i] = 8'h00;

    //        rst hold v0 a0 d0     v1 a1 d1     r0 r1 wr addr data   pend   lg
    // single request
    vt[0]  = '{0, 0, 1, 3, 8'h5A, 0, 0, 8'h00, 1, 0, 1, 3, 8'h5A, 8'h08, 0};
    vt[1]  = '{0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0};
    // reset ignores valid requests
    vt[2]  = '{1, 0, 1, 1, 8'h11, 1, 2, 8'h22, 0, 0, 0, 0, 8'h00, 8'h00, 1};
    // contention out of reset
    vt[3]  = '{0, 0, 1, 1, 8'h11, 1, 2, 8'h22, 1, 0, 1, 1, 8'h11, 8'h02, 0};
    vt[4]  = '{0, 0, 1, 1, 8'h11, 1, 2, 8'h22, 0, 1, 1, 2, 8'h22, 8'h04, 1};
    vt[5]  = '{0, 0, 1, 1, 8'h11, 1, 2, 8'h22, 1, 0, 1, 1, 8'h11, 8'h02, 0};
    vt[6]  = '{0, 0, 1, 1, 8'h11, 1, 2, 8'h22, 0, 1, 1, 2, 8'h22, 8'h04, 1};
    // same-address collision
    vt[7]  = '{0, 0, 1, 5, 8'hAA, 1, 5, 8'hBB, 1, 0, 1, 5, 8'hAA, 8'h20, 0};
    vt[8]  = '{0, 0, 0, 0, 8'h00, 1, 5, 8'hBB, 0, 1, 1, 5, 8'hBB, 8'h20, 1};
    // hold
    vt[9]  = '{0, 1, 0, 0, 8'h00, 1, 7, 8'hC3, 0, 0, 0, 0, 8'h00, 8'h00, 1};
    vt[10] = '{0, 1, 0, 0, 8'h00, 1, 7, 8'hC3, 0, 0, 0, 0, 8'h00, 8'h00, 1};
    vt[11] = '{0, 1, 0, 0, 8'h00, 1, 7, 8'hC3, 0, 0, 0, 0, 8'h00, 8'h00, 1};
    vt[12] = '{0, 0, 0, 0, 8'h00, 1, 7, 8'hC3, 0, 1, 1, 7, 8'hC3, 8'h80, 1};
    vt[13] = '{0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 1};
    // reset right after an accepted write
    vt[14] = '{0, 0, 1, 4, 8'h99, 0, 0, 8'h00, 1, 0, 1, 4, 8'h99, 8'h10, 0};
    vt[15] = '{1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 1};
    // first edge after reset, address 0
    vt[16] = '{0, 0, 1, 0, 8'h3C, 0, 0, 8'h00, 1, 0, 1, 0, 8'h3C, 8'h01, 0};
    // hold with a write in the stage: it completes, no grant
    vt[17] = '{0, 1, 1, 6, 8'h66, 1, 6, 8'h77, 0, 0, 0, 0, 8'h00, 8'h00, 0};

    drive('{1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 1});
    repeat (2) @(posedge clk);
    #1;
    chk("reset rf_write", 32'(bus.rf_write), 0);
    chk("reset rf_inaddress", 32'(bus.rf_inaddress), 0);
    chk("reset rf_in", 32'(bus.rf_in), 0);
    chk("reset pending", 32'(bus.pending), 0);
    chk("reset last_grant", 32'(bus.last_grant), 1);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(vt[i]);
      #1;
      chk($sformatf("v%0d req0_ready", i),
          32'(bus.req0_ready), 32'(vt[i].r0));
      chk($sformatf("v%0d req1_ready", i),
          32'(bus.req1_ready), 32'(vt[i].r1));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d rf_write", i),
          32'(bus.rf_write), 32'(vt[i].wr));
      chk($sformatf("v%0d pending", i),
          32'(bus.pending), 32'(vt[i].pend));
      chk($sformatf("v%0d last_grant", i),
          32'(bus.last_grant), 32'(vt[i].lg));
      if (vt[i].wr || vt[i].rst) begin
        chk($sformatf("v%0d rf_inaddress", i),
            32'(bus.rf_inaddress), 32'(vt[i].addr));
        chk($sformatf("v%0d rf_in", i),
            32'(bus.rf_in), 32'(vt[i].data));
      end
    end

    // Idle stretch: nothing valid for 10 cycles.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive('{0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0});
      #1;
      chk($sformatf("idle%0d ready", c),
          32'({bus.req0_ready, bus.req1_ready}), 0);
      @(posedge clk);
      #1;
      chk($sformatf("idle%0d rf_write", c),
          32'(bus.rf_write), 0);
    end

    // Register file contents after the sequences.
    chk("reg3", 32'(rf_mem[3]), 32'h5A);
    chk("reg5 collision", 32'(rf_mem[5]), 32'hBB);
    chk("reg7 after hold", 32'(rf_mem[7]), 32'hC3);
    chk("reg4 dropped", 32'(rf_mem[4]), 32'h00);
    chk("reg0", 32'(rf_mem[0]), 32'h3C);
    chk("reg6 untouched", 32'(rf_mem[6]), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

- Shares the single write port of the 8 x 8-bit register file between two writeback requesters:
  - requester 0: ALU result;
  - requester 1: data-memory load.
- Uses round-robin arbitration.
- Registers the winning request into one output stage that drives the register file WRITE, INADDRESS and IN pins.
- Exports a per-register pending mask so the hazard/stall logic can see writes that are in flight.

## Interface
Parameters:
- DATA_W, 8, write data width.
- ADDR_W, 3, register address width.
- NREG, 8, number of registers (2**ADDR_W).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  reset, synchronous, active-high.
- hold  input  1  processor stall; blocks all new grants while high.
- req0_valid  input  1  ALU writeback request.
- req0_addr  input  ADDR_W  ALU destination register.
- req0_data  input  DATA_W  ALU result.
- req0_ready  output  1  request 0 accepted this cycle.
- req1_valid, req1_addr, req1_data  input  1/ADDR_W/DATA_W  load writeback request.
- req1_ready  output  1  request 1 accepted this cycle.
- rf_write  output  1  drives register file WRITE.
- rf_inaddress  output  ADDR_W  drives register file INADDRESS.
- rf_in  output  DATA_W  drives register file IN.
- pending  output  NREG  bit k = 1 while a write to register k is in the output stage.
- last_grant  output  1  requester granted most recently (round-robin pointer).

## Operation
- Handshake is valid/ready, and a transfer happens on an edge where valid & ready are both 1.
  - ready is combinational from valid, hold, RESET and the pointer.
  - A requester holds valid, addr and data stable until it is accepted.
- Grant rules, with RESET = 0 and hold = 0:
  - Exactly one requester valid: it gets ready = 1.
  - Both valid: the requester other than last_grant wins; the loser sees ready = 0 and retries.
  - Neither valid: both ready = 0.
- hold = 1 or RESET = 1: both ready = 0.
- Pointer update:
  - last_grant updates to the winner on every transfer edge.
  - last_grant holds otherwise.
  - Reset value 1, so requester 0 wins the first tie.
- Output stage, two states:
  - IDLE: rf_write = 0.
  - WRITE: rf_write = 1, with rf_inaddress and rf_in equal to the accepted request.
  - Any transfer edge → WRITE with the new address and data.
  - An edge with no transfer → IDLE.
  - The register file always accepts, so a new transfer can follow in back-to-back cycles; the stage stays in WRITE and reloads.
- pending = one-hot decode of rf_inaddress while in WRITE; 0 in IDLE.
- Same-address collision: both requesters target register k in the same cycle.
  - The winner is written first and the loser in a later cycle.
  - Final register content is the loser's data, i.e. the later write wins.
- Address 0 is an ordinary register and gets no special treatment.
- Reset:
  - On an edge with RESET = 1: state → IDLE, rf_write = 0, rf_inaddress = 0, rf_in = 0, pending = 0, last_grant = 1.
  - A request accepted on the edge before RESET rises is dropped; it is never written.
  - Requesters must re-present after RESET falls.

## Timing
- All outputs except req*_ready are registered.
- Latency, for a transfer on edge N:
  - rf_write is high from edge N until edge N+1.
  - The register file captures the data on edge N+1.
  - The register reads back valid after the register file read delay.
- rf_write pulses for exactly one cycle per accepted request; there are no duplicate writes.
- Throughput is one write per cycle.
- Worst-case wait for a continuously valid loser is one cycle (round-robin), unless hold is asserted.
- hold asserted mid-stream: the write already in the stage still completes on the next edge; no new grant is made.
- After RESET deasserts, the first grant is possible on the first edge with RESET = 0.

## Test plan
- Single request: req0 valid with addr = 3, data = 0x5A → req0_ready = 1; next cycle rf_write = 1, rf_inaddress = 3, rf_in = 0x5A, pending = 0x08; the cycle after, rf_write = 0 and pending = 0.
- Contention: both valid every cycle for 4 cycles, req0 (addr 1, data 0x11), req1 (addr 2, data 0x22), out of reset → grants in order 0, 1, 0, 1 and last_grant toggles; rf_write stays high for 4 consecutive cycles.
- Collision: both valid with addr = 5, data 0xAA (req0) and 0xBB (req1) → first write 0xAA, then 0xBB; pending = 0x20 for two consecutive cycles; register 5 ends at 0xBB.
- Hold: hold = 1 for 3 cycles with req1 valid (addr 7, data 0xC3) → req1_ready = 0 throughout and no rf_write; hold falls → accepted, rf_in = 0xC3 one cycle later.
- Reset mid-operation: a transfer of addr 4, data 0x99 is followed by RESET = 1 on the next edge → rf_write = 0, pending = 0, last_grant = 1; register 4 is not written.
- Idle: no requests for 10 cycles → rf_write stays 0 and both ready signals stay 0.
